fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised forwarding and hazard controller for the in-order pipeline, generalising the 2-operand, fixed-latency forwarding decision to N source operands, configurable register-address width and variable result latency. It tracks, per architectural register, the cycles until a pending result can be forwarded. From this it produces the ID-stage stall and registered EX-stage forward selects. It sits between the decode stage and the EX operand muxes.

## Interface
Parameters:
- AW, 5, register address width; NREG = 2**AW
- NPORT, 2, source operands per instruction
- MAXLAT, 4, maximum result latency in cycles (>= 2); LW = $clog2(MAXLAT+1)

Ports:
- iClk  in  1  clock
- iReset  in  1  reset, asynchronous, active-high
- iIdValid  in  1  valid instruction in ID
- iIdRegSrc  in  NPORT*AW  source register addresses, port p at bits [p*AW +: AW]
- iIdRegRd  in  AW  destination register
- iIdRegWrite  in  1  instruction writes iIdRegRd
- iIdLat  in  LW  result latency: 1 ALU, 2 load, >2 multi-cycle
- iHold  in  1  global pipeline freeze
- iFlush  in  1  kill instruction in ID (branch resolved in EX)
- oStall  out  1  combinational; ID instruction must hold
- oForwardCmd  out  2*NPORT  registered, per port for instruction in EX: 00 regfile, 01 MEM, 10 WB, 11 never driven
- oExValid  out  1  registered; EX slot holds an issued instruction
- oBusy  out  NREG  bit r = cnt[r] != 0

## Operation
- State: per register r, cnt[r] (LW bits) and tag lat1[r] (1 bit, producer latency == 1). Register 0 is never tracked: cnt[0] stays 0; port reading r0 never stalls, gets 00.
- Effective latency L = iIdLat clamped to [1, MAXLAT] (0 -> 1, >MAXLAT -> MAXLAT).
- RAW stall: any port p with src != 0 and cnt[src] >= 2.
- WAW stall: iIdRegWrite, iIdRegRd != 0 and cnt[iIdRegRd] > L.
- oStall = iIdValid & (RAW | WAW). Not gated by iHold or iFlush.
- Issue = iIdValid & !oStall & !iHold & !iFlush.
- Per cycle, when !iHold: every nonzero cnt decrements by 1. On issue with write to rd != 0: cnt[rd] <= L and lat1[rd] <= (L == 1). The load overrides the decrement for that rd.
- EX slot update, when !iHold:
  - On issue: oExValid <= 1. For each port, with s = src: oForwardCmd <= 01 if cnt[s]==1 & lat1[s]; 10 if cnt[s]==1 & !lat1[s]; else 00.
  - Otherwise (stall, flush, no valid): bubble, oExValid <= 0, oForwardCmd <= 0.
- iHold: cnt, lat1, oForwardCmd and oExValid all keep their values.
- Result placement: an L=1 producer is on the MEM path one cycle after its issue edge. An L>=2 producer is on the WB path L cycles after the issue edge. When cnt reaches 0 the register file is already written (write-first regfile), so 00 is correct.
- iFlush does not touch counters; producers already issued complete.
- oBusy is derived combinationally from cnt.

## Timing
- Reset (async): all cnt = 0, lat1 = 0, oForwardCmd = 0, oExValid = 0, oBusy = 0. oStall is then 0 for any input.
- Reset asserted mid-operation clears all pending state immediately. The first issue after deassertion sees no hazards.
- Stall penalty for a dependent instruction directly following its producer:
  - L=1: 0 cycles, forward 01.
  - L=2: 1 cycle, forward 10.
  - L=k: k-1 cycles, forward 10.
- Forward select latency: oForwardCmd is valid in the cycle after the issue edge, aligned with the instruction in EX.
- Simultaneous events:
  - Issue reading and writing the same register uses the pre-update cnt for its own sources.
  - Both ports naming the same register get identical commands.
  - iFlush together with iHold: hold wins, the slot is unchanged. Flush takes effect on the first cycle without hold, provided iFlush is still asserted.
- If a stalled instruction sees cnt=1 on one port but is held by another port, it re-evaluates the next cycle with cnt=0 and gets 00.

## Test plan
- Back-to-back ALU chain: $3 <- L=1, then consumer reads $3 on port 0 -> no stall, next cycle oForwardCmd[1:0]=01, oExValid=1.
- Load-use: $5 <- L=2, consumer reads $5 on port 1 -> oStall=1 for exactly 1 cycle, EX bubble (cmd 00, oExValid=0), then oForwardCmd[3:2]=10.
- Multi-cycle L=4 to $7, consumer reads $7 -> 3 stall cycles, then 10. Also: second writer to $7 with L=1 issued 1 cycle after the L=4 write -> WAW stall until cnt[7] <= 1.
- r0 and independence: writer to $0 with L=4, consumer reads $0 on both ports -> no stall, cmds 00, oBusy all 0.
- iHold for 3 cycles during a load-use stall -> cnt, oBusy and oForwardCmd frozen; stall count resumes unchanged after release. iFlush with a valid non-hazard instruction -> no issue, bubble in EX, counters untouched.
- Async reset asserted mid-clock with cnt[9]=3 -> oBusy=0, oExValid=0 and oForwardCmd=0 immediately. A consumer of $9 issues next cycle without stall, cmd 00.

Source files
------------

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard
//  Description : Forwarding / hazard controller for the in-order pipeline.
//                Tracks, per architectural register, the cycles until a
//                pending result can be forwarded, and from that produces the
//                ID-stage stall and the registered EX-stage forward selects
//                for NPORT source operands with variable result latency.
//  Ports       : iClk, iReset        clock, async active-high reset
//                iIdValid            valid instruction in ID
//                iIdRegSrc           NPORT packed source register addresses
//                iIdRegRd/Write/Lat  destination, write enable, latency
//                iHold, iFlush       pipeline freeze, kill ID instruction
//                oStall              combinational ID hold request
//                oForwardCmd         registered per-port EX forward select
//                                    (00 regfile, 01 MEM, 10 WB)
//                oExValid            registered EX slot occupancy
//                oBusy               per-register pending-result flags
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_scoreboard #(
  parameter  int AW     = 5,
  parameter  int NPORT  = 2,
  parameter  int MAXLAT = 4,
  localparam int NREG   = 2**AW,
  localparam int LW     = $clog2(MAXLAT + 1)
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iIdValid,
  input  logic [NPORT*AW-1:0]   iIdRegSrc,
  input  logic [AW-1:0]         iIdRegRd,
  input  logic                  iIdRegWrite,
  input  logic [LW-1:0]         iIdLat,
  input  logic                  iHold,
  input  logic                  iFlush,
  output logic                  oStall,
  output logic [2*NPORT-1:0]    oForwardCmd,
  output logic                  oExValid,
  output logic [NREG-1:0]       oBusy
);

  // --------------------------------------------------------------------------
  // Effective latency: 0 behaves as a single-cycle ALU op, anything beyond
  // MAXLAT saturates.
  // --------------------------------------------------------------------------
  logic [LW-1:0] w_lat;

  always_comb begin
    if (iIdLat == '0) begin
      w_lat = LW'(1);
    end else if (iIdLat > LW'(MAXLAT)) begin
      w_lat = LW'(MAXLAT);
    end else begin
      w_lat = iIdLat;
    end
  end

  // Per-register state views (register 0 reads as permanently idle).
  logic [LW-1:0]      w_cnt [NREG];
  logic [NREG-1:0]    w_lat1;

  // Per-port hazard and forward decisions.
  logic [AW-1:0]      w_src [NPORT];
  logic [NPORT-1:0]   w_port_raw;
  logic [2*NPORT-1:0] w_fwd;

  logic w_raw;
  logic w_waw;
  logic w_issue;
  logic w_load;

  // --------------------------------------------------------------------------
  // Source-port decode. A count of 1 means the producer's result is sitting
  // on a bypass path this cycle; the tag picks which one. Counts of 2 or more
  // mean the value does not exist yet, so the consumer must wait.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign w_src[p]      = iIdRegSrc[p*AW +: AW];
    assign w_port_raw[p] = (w_src[p] != '0) && (w_cnt[w_src[p]] >= LW'(2));
    assign w_fwd[2*p +: 2] =
      (w_cnt[w_src[p]] == LW'(1)) ? (w_lat1[w_src[p]] ? 2'b01 : 2'b10) : 2'b00;
  end

  assign w_raw = |w_port_raw;

  // A younger writer must not land before an older, slower one to the same
  // register, so it waits until the older result is no further out than its own.
  assign w_waw = iIdRegWrite && (iIdRegRd != '0) && (w_cnt[iIdRegRd] > w_lat);

  assign oStall  = iIdValid & (w_raw | w_waw);
  assign w_issue = iIdValid & ~oStall & ~iHold & ~iFlush;
  assign w_load  = w_issue & iIdRegWrite & (iIdRegRd != '0);

  // --------------------------------------------------------------------------
  // Per-register countdown and latency tag.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_cnt[r]  = '0;
      assign w_lat1[r] = 1'b0;
    end else begin : g_track
      logic [LW-1:0] cnt_q;
      logic [LW-1:0] cnt_d;
      logic          lat1_q;
      logic          lat1_d;

      always_comb begin
        cnt_d  = cnt_q;
        lat1_d = lat1_q;
        if (!iHold) begin
          // A new producer replaces whatever countdown was in flight.
          if (w_load && (iIdRegRd == AW'(r))) begin
            cnt_d  = w_lat;
            lat1_d = (w_lat == LW'(1));
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LW'(1);
          end
        end
      end

      always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
          cnt_q  <= '0;
          lat1_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          lat1_q <= lat1_d;
        end
      end

      assign w_cnt[r]  = cnt_q;
      assign w_lat1[r] = lat1_q;
    end

    assign oBusy[r] = (w_cnt[r] != '0);
  end

  // --------------------------------------------------------------------------
  // EX slot: forward selects travel with the issuing instruction; anything
  // that does not issue becomes a bubble. Hold freezes the slot.
  // --------------------------------------------------------------------------
  logic [2*NPORT-1:0] fwd_q;
  logic [2*NPORT-1:0] fwd_d;
  logic               exvalid_q;
  logic               exvalid_d;

  always_comb begin
    fwd_d     = fwd_q;
    exvalid_d = exvalid_q;
    if (!iHold) begin
      if (w_issue) begin
        fwd_d     = w_fwd;
        exvalid_d = 1'b1;
      end else begin
        fwd_d     = '0;
        exvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      fwd_q     <= '0;
      exvalid_q <= 1'b0;
    end else begin
      fwd_q     <= fwd_d;
      exvalid_q <= exvalid_d;
    end
  end

  assign oForwardCmd = fwd_q;
  assign oExValid    = exvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_scoreboard
//  Description : Directed self-checking bench for fwd_scoreboard with default
//                parameters (AW=5, NPORT=2, MAXLAT=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_scoreboard;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iIdValid;
  logic [9:0]  iIdRegSrc;
  logic [4:0]  iIdRegRd;
  logic        iIdRegWrite;
  logic [2:0]  iIdLat;
  logic        iHold;
  logic        iFlush;
  logic        oStall;
  logic [3:0]  oForwardCmd;
  logic        oExValid;
  logic [31:0] oBusy;

  int errors = 0;
  int checks = 0;

  fwd_scoreboard dut (
    .iClk        (iClk),
    .iReset      (iReset),
    .iIdValid    (iIdValid),
    .iIdRegSrc   (iIdRegSrc),
    .iIdRegRd    (iIdRegRd),
    .iIdRegWrite (iIdRegWrite),
    .iIdLat      (iIdLat),
    .iHold       (iHold),
    .iFlush      (iFlush),
    .oStall      (oStall),
    .oForwardCmd (oForwardCmd),
    .oExValid    (oExValid),
    .oBusy       (oBusy)
  );

  always #5 iClk = ~iClk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] rd, input logic wr, input logic [2:0] lat);
    iIdValid    = v;
    iIdRegSrc   = {s1, s0};
    iIdRegRd    = rd;
    iIdRegWrite = wr;
    iIdLat      = lat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0);
    iHold  = 1'b0;
    iFlush = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (6) step();
  endtask

  task automatic test_reset();
    step();
    checks++; if (oBusy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", oBusy, 32'h0); end
    checks++; if (oExValid !== 1'b0) begin errors++; $display("FAIL reset_exvalid: got %b expected 0", oExValid); end
    checks++; if (oForwardCmd !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", oForwardCmd); end
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'd4);
    #1;
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", oStall); end
    iReset = 1'b0;
    idle();
    step();
  endtask

  task automatic test_alu_chain();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd1);
    #1;
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL alu_prod_stall: got %b expected 0", oStall); end
    step();
    checks++; if (oBusy !== 32'h0000_0008) begin errors++; $display("FAIL alu_busy: got %h expected %h", oBusy, 32'h8); end
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 3'd1);
    #1;
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL alu_cons_stall: got %b expected 0", oStall); end
    step();
    checks++; if (oForwardCmd !== 4'b0001) begin errors++; $display("FAIL alu_fwd: got %b expected 0001", oForwardCmd); end
    checks++; if (oExValid !== 1'b1) begin errors++; $display("FAIL alu_exvalid: got %b expected 1", oExValid); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 3'd2);
    step();
    drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 3'd1);
    #1;
    checks++; if (oStall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %b expected 1", oStall); end
    step();
    checks++; if (oExValid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %b expected 0", oExValid); end
    checks++; if (oForwardCmd !== 4'b0000) begin errors++; $display("FAIL lu_bubble_fwd: got %b expected 0000", oForwardCmd); end
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %b expected 0", oStall); end
    step();
    checks++; if (oForwardCmd !== 4'b1000) begin errors++; $display("FAIL lu_fwd: got %b expected 1000", oForwardCmd); end
    checks++; if (oExValid !== 1'b1) begin errors++; $display("FAIL lu_exvalid: got %b expected 1", oExValid); end
    drain();
  endtask

  // Counts stall cycles of the instruction currently driven in ID.
  task automatic count_stalls(output int n);
    n = 0;
    #1;
    while (oStall === 1'b1 && n < 12) begin
      step();
      #1;
      n++;
    end
  endtask

  task automatic test_multicycle();
    int n;
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 3'd4);
    step();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 3'd1);
    count_stalls(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL mc_stalls: got %0d expected 3", n); end
    step();
    checks++; if (oForwardCmd !== 4'b0010) begin errors++; $display("FAIL mc_fwd: got %b expected 0010", oForwardCmd); end
    drain();
    // WAW: younger L=1 writer behind an L=4 writer to the same register.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 3'd4);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 3'd1);
    count_stalls(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL waw_stalls: got %0d expected 3", n); end
    step();
    checks++; if (oBusy !== 32'h0000_0080) begin errors++; $display("FAIL waw_busy: got %h expected %h", oBusy, 32'h80); end
    checks++; if (oExValid !== 1'b1) begin errors++; $display("FAIL waw_exvalid: got %b expected 1", oExValid); end
    idle();
    step();
    checks++; if (oBusy !== 32'h0) begin errors++; $display("FAIL waw_done: got %h expected %h", oBusy, 32'h0); end
    drain();
  endtask

  task automatic test_clamp();
    int n;
    // Latency 7 saturates to 4.
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 3'd7);
    step();
    drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 3'd1);
    count_stalls(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL clamp_hi_stalls: got %0d expected 3", n); end
    drain();
    // Latency 0 behaves as 1.
    drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 3'd0);
    step();
    drive(1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 3'd1);
    #1;
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL clamp_lo_stall: got %b expected 0", oStall); end
    step();
    checks++; if (oForwardCmd !== 4'b0100) begin errors++; $display("FAIL clamp_lo_fwd: got %b expected 0100", oForwardCmd); end
    drain();
  endtask

  task automatic test_r0_same_reg();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'd4);
    step();
    checks++; if (oBusy !== 32'h0) begin errors++; $display("FAIL r0_busy: got %h expected %h", oBusy, 32'h0); end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'd1);
    #1;
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b expected 0", oStall); end
    step();
    checks++; if (oForwardCmd !== 4'b0000 || oExValid !== 1'b1) begin errors++; $display("FAIL r0_fwd: got %b/%b expected 0000/1", oForwardCmd, oExValid); end
    drain();
    // Reads and rewrites $4 on both ports: pre-update state governs the forward.
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 3'd1);
    step();
    drive(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 3'd2);
    #1;
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL same_stall: got %b expected 0", oStall); end
    step();
    checks++; if (oForwardCmd !== 4'b0101) begin errors++; $display("FAIL same_fwd: got %b expected 0101", oForwardCmd); end
    checks++; if (oBusy !== 32'h0000_0010) begin errors++; $display("FAIL same_busy: got %h expected %h", oBusy, 32'h10); end
    drain();
  endtask

  task automatic test_hold();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd1);
    step();
    drive(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 3'd2);
    step();
    drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 3'd1);
    iHold = 1'b1;
    #1;
    checks++; if (oStall !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b expected 1", oStall); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (oForwardCmd !== 4'b0001 || oExValid !== 1'b1 || oBusy !== 32'h0000_0020) begin
        errors++;
        $display("FAIL hold_frozen%0d: got fwd=%b ex=%b busy=%h expected 0001/1/%h", i, oForwardCmd, oExValid, oBusy, 32'h20);
      end
    end
    iHold = 1'b0;
    #1;
    checks++; if (oStall !== 1'b1) begin errors++; $display("FAIL hold_resume_stall: got %b expected 1", oStall); end
    step();
    checks++; if (oExValid !== 1'b0 || oStall !== 1'b0) begin errors++; $display("FAIL hold_bubble: got ex=%b stall=%b expected 0/0", oExValid, oStall); end
    step();
    checks++; if (oForwardCmd !== 4'b1000) begin errors++; $display("FAIL hold_fwd: got %b expected 1000", oForwardCmd); end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 3'd3);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 3'd3);
    iFlush = 1'b1;
    iHold  = 1'b1;
    step();
    checks++; if (oExValid !== 1'b1 || oBusy !== 32'h0000_0040) begin errors++; $display("FAIL flush_hold: got ex=%b busy=%h expected 1/%h", oExValid, oBusy, 32'h40); end
    iHold = 1'b0;
    step();
    checks++; if (oExValid !== 1'b0 || oForwardCmd !== 4'b0000) begin errors++; $display("FAIL flush_bubble: got ex=%b fwd=%b expected 0/0000", oExValid, oForwardCmd); end
    checks++; if (oBusy !== 32'h0000_0040) begin errors++; $display("FAIL flush_cnt: got %h expected %h", oBusy, 32'h40); end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 3'd1);
    step();
    drive(1'b1, 5'd3, 5'd0, 5'd9, 1'b1, 3'd3);
    step();
    checks++; if (oForwardCmd !== 4'b0001 || oBusy !== 32'h0000_0200) begin errors++; $display("FAIL ar_pre: got fwd=%b busy=%h expected 0001/%h", oForwardCmd, oBusy, 32'h200); end
    idle();
    #2;
    iReset = 1'b1;
    #1;
    checks++; if (oBusy !== 32'h0 || oExValid !== 1'b0 || oForwardCmd !== 4'b0000) begin errors++; $display("FAIL ar_clear: got busy=%h ex=%b fwd=%b expected 0/0/0000", oBusy, oExValid, oForwardCmd); end
    #1;
    iReset = 1'b0;
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 3'd1);
    #1;
    checks++; if (oStall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b expected 0", oStall); end
    step();
    checks++; if (oForwardCmd !== 4'b0000 || oExValid !== 1'b1) begin errors++; $display("FAIL ar_issue: got fwd=%b ex=%b expected 0000/1", oForwardCmd, oExValid); end
    drain();
  endtask

  initial begin
    iReset = 1'b1;
    idle();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_multicycle();
    test_clamp();
    test_r0_same_reg();
    test_hold();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
